// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared defaults and entry type for the write-back controller
package reg_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 2;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dst;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_ctrl_fifo.sv
// rtl/reg_wb_ctrl_fifo.sv - wb_fifo: in-order result queue with per-entry visibility
module wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_reg,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [ADDR_W-1:0]             head_reg,
    output logic [DATA_W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] reg_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic                         do_push;
    logic                         do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_reg  = reg_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign ent_reg   = reg_mem;

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            reg_mem[wr_ptr]  <= push_reg;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the head is below the occupancy
    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
        end
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - write-back arbiter, queue and register-file writer (option: REG_WB_SCOREBOARD_EN)
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_reg,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_reg,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    output logic                   regwrite,
    output logic [ADDR_W-1:0]      writereg,
    output logic [DATA_W-1:0]      writedata,
    input  logic [ADDR_W-1:0]      readreg1,
    input  logic [ADDR_W-1:0]      readreg2,
    output logic                   pend1,
    output logic                   pend2,
    output logic [$clog2(DEPTH):0] count
);

    logic                         push;
    logic [ADDR_W-1:0]            push_reg;
    logic [DATA_W-1:0]            push_data;
    logic                         pop;
    logic [ADDR_W-1:0]            head_reg;
    logic [DATA_W-1:0]            head_data;
    logic                         full;
    logic                         empty;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_reg;

    // Readies look only at registered occupancy; memory always wins a tie
    assign mem_ready = ~full;
    assign alu_ready = ~full & ~mem_valid;

    assign push      = (mem_valid & mem_ready) | (alu_valid & alu_ready);
    assign push_reg  = mem_valid ? mem_reg  : alu_reg;
    assign push_data = mem_valid ? mem_data : alu_data;
    assign pop       = ~empty;

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_reg  (push_reg),
        .push_data (push_data),
        .pop       (pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ent_valid (ent_valid),
        .ent_reg   (ent_reg)
    );

    // Registered write port: one queue head per cycle, index/data hold when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite  <= 1'b0;
            writereg  <= '0;
            writedata <= '0;
        end else if (pop) begin
            regwrite  <= 1'b1;
            writereg  <= head_reg;
            writedata <= head_data;
        end else begin
            regwrite  <= 1'b0;
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    // Hazard probe: a read index is pending if it is being written now or still queued
    always_comb begin
        pend1 = regwrite && (writereg == readreg1);
        pend2 = regwrite && (writereg == readreg2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_reg[i] == readreg1)) pend1 = 1'b1;
            if (ent_valid[i] && (ent_reg[i] == readreg2)) pend2 = 1'b1;
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{ent_valid, ent_reg, readreg1, readreg2};
    assign pend1 = 1'b0;
    assign pend2 = 1'b0;
`endif

endmodule
